// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions. Holds the FSM state encoding, the
//                line levels and the power-on divisor. Both the TX and RX
//                sides import this package.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // State encoding for the frame sequencer
  localparam logic [2:0] c_ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] c_ST_START_ENC  = 3'd1;
  localparam logic [2:0] c_ST_DATA_ENC   = 3'd2;
  localparam logic [2:0] c_ST_PARITY_ENC = 3'd3;
  localparam logic [2:0] c_ST_STOP_ENC   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = c_ST_IDLE_ENC,
    ST_START  = c_ST_START_ENC,
    ST_DATA   = c_ST_DATA_ENC,
    ST_PARITY = c_ST_PARITY_ENC,
    ST_STOP   = c_ST_STOP_ENC
  } uart_state_e;

  // Line levels
  localparam logic c_TXD_IDLE  = 1'b1;
  localparam logic c_START_BIT = 1'b0;

  // Divisor held by the config latch out of reset (any non-zero value works;
  // the baud counter is held clear until the first frame loads its own).
  localparam int c_DEFAULT_DIV = 16;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_ctrl_if
//  Description : Bundle between the TX controller, the TX FIFO and the APB
//                register block.
//  Signals     : tx_en, baud_div, parity_en, parity_odd, stop2 - frame config
//                fifo_dout, fifo_empty                          - FIFO head
//                fifo_rd_en                                     - FIFO pop
//                txd, busy, tx_done                             - status/line
//  Modports    : master - environment side (drives config and FIFO head)
//                slave  - controller side
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
);

  logic                  tx_en;
  logic [DIV_WIDTH-1:0]  baud_div;
  logic                  parity_en;
  logic                  parity_odd;
  logic                  stop2;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic                  txd;
  logic                  busy;
  logic                  tx_done;

  modport master (
    output tx_en, baud_div, parity_en, parity_odd, stop2,
    output fifo_dout, fifo_empty,
    input  fifo_rd_en, txd, busy, tx_done
  );

  modport slave (
    input  tx_en, baud_div, parity_en, parity_odd, stop2,
    input  fifo_dout, fifo_empty,
    output fifo_rd_en, txd, busy, tx_done
  );

endinterface : uart_tx_ctrl_if
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Bit-period counter. Counts 0..div-1 and pulses o_bit_end on
//                the last cycle of each bit, then restarts. i_clear holds the
//                counter at zero so the first bit after release is full length.
//  Ports       : clk, rst_n  - clock, async active-low reset
//                i_clear     - hold counter at 0, suppress o_bit_end
//                i_div       - cycles per bit (0 treated as 1)
//                o_bit_end   - last cycle of the current bit
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_bit_end
);

  localparam logic [DIV_WIDTH-1:0] c_ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] w_div_eff;
  logic                 w_at_end;

  // A zero divisor would make div-1 wrap to all-ones; clamp it instead.
  assign w_div_eff = (i_div == '0) ? c_ONE : i_div;
  assign w_at_end  = (r_cnt == (w_div_eff - c_ONE));
  assign o_bit_end = !i_clear && w_at_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || w_at_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_ONE;
    end
  end

endmodule : uart_baud_gen
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_ctrl
//  Description : Pops bytes from a first-word-fall-through TX FIFO and
//                serialises each as start, DATA_WIDTH data bits LSB-first,
//                optional parity and one or two stop bits. Frame config is
//                captured on the pop edge and held for the whole frame.
//  Ports       : clk, rst_n - clock, async active-low reset
//                bus (slave)- config in, FIFO head in, FIFO pop out,
//                             txd / busy / tx_done out
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_ctrl_if.slave bus
);

  localparam int c_BCW = $clog2(DATA_WIDTH) + 1;

  uart_state_e           r_state;
  uart_state_e           w_state_next;

  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_next;
  logic [c_BCW-1:0]      r_bit_cnt;
  logic                  r_stop_cnt;
  logic [DIV_WIDTH-1:0]  r_div_q;
  logic                  r_par_en_q;
  logic                  r_stop2_q;
  logic                  r_par_bit;
  logic                  r_txd;
  logic                  r_busy;
  logic                  r_tx_done;

  logic                  w_rd_en;
  logic                  w_bit_end;
  logic                  w_last_data;
  logic                  w_frame_end;
  logic                  w_txd_next;

  // Only the controller pops, and only from IDLE with data present.
  assign w_rd_en     = (r_state == ST_IDLE) && bus.tx_en && !bus.fifo_empty;
  assign w_last_data = (r_bit_cnt == c_BCW'(DATA_WIDTH - 1));

  uart_baud_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (r_state == ST_IDLE),
    .i_div     (r_div_q),
    .o_bit_end (w_bit_end)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state, next shift value and next line level. txd is registered, so
  // its value is derived from the state being entered, not the current one.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_frame_end  = 1'b0;
    w_shift_next = r_shift;
    w_txd_next   = c_TXD_IDLE;

    unique case (r_state)
      ST_IDLE: begin
        if (w_rd_en) begin
          w_state_next = ST_START;
          w_shift_next = bus.fifo_dout;
        end
      end
      ST_START: begin
        if (w_bit_end) w_state_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_shift_next = r_shift >> 1;
          if (w_last_data) w_state_next = r_par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (w_bit_end) w_state_next = ST_STOP;
      end
      ST_STOP: begin
        // Second stop bit is pending while r_stop_cnt is still 0 with stop2.
        if (w_bit_end && (!r_stop2_q || r_stop_cnt)) begin
          w_state_next = ST_IDLE;
          w_frame_end  = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    unique case (w_state_next)
      ST_START:  w_txd_next = c_START_BIT;
      ST_DATA:   w_txd_next = w_shift_next[0];
      ST_PARITY: w_txd_next = r_par_bit;
      default:   w_txd_next = c_TXD_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: config latch, shift register, bit counters, outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_div_q    <= DIV_WIDTH'(c_DEFAULT_DIV);
      r_par_en_q <= 1'b0;
      r_stop2_q  <= 1'b0;
      r_par_bit  <= 1'b0;
      r_txd      <= c_TXD_IDLE;
      r_busy     <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      r_shift   <= w_shift_next;
      r_txd     <= w_txd_next;
      r_tx_done <= w_frame_end;

      if (w_rd_en) begin
        r_bit_cnt  <= '0;
        r_stop_cnt <= 1'b0;
        r_div_q    <= (bus.baud_div == '0) ? DIV_WIDTH'(1) : bus.baud_div;
        r_par_en_q <= bus.parity_en;
        r_stop2_q  <= bus.stop2;
        r_par_bit  <= (^bus.fifo_dout) ^ bus.parity_odd;
        r_busy     <= 1'b1;
      end else begin
        if (w_frame_end) r_busy <= 1'b0;
        if ((r_state == ST_DATA) && w_bit_end) r_bit_cnt <= r_bit_cnt + c_BCW'(1);
        if ((r_state == ST_STOP) && w_bit_end) r_stop_cnt <= 1'b1;
      end
    end
  end

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.txd        = r_txd;
  assign bus.busy       = r_busy;
  assign bus.tx_done    = r_tx_done;

endmodule : uart_tx_ctrl
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_ctrl
//  Description : Self-checking bench for uart_tx_ctrl. A queue models the
//                FWFT FIFO; each pop expands the byte into the expected txd
//                waveform (one entry per clock) from the frame rules, and the
//                DUT outputs are compared against it every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

  localparam int DW = 8;
  localparam int VW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DATA_WIDTH(DW), .DIV_WIDTH(VW)) bus ();

  uart_tx_ctrl #(.DATA_WIDTH(DW), .DIV_WIDTH(VW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [7:0] fifo_q[$];
  logic       exp_q[$];     // expected txd, one entry per clock of the frame
  logic       exp_done = 1'b0;
  int         rd_cycles[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void fifo_drive();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_dout  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endfunction

  function automatic void push(input logic [7:0] d);
    fifo_q.push_back(d);
    fifo_drive();
  endfunction

  // Expand one byte into its line waveform using the config seen on the pop.
  function automatic void model_load(input logic [7:0] d);
    int   div;
    logic bits[$];
    div = (bus.baud_div == '0) ? 1 : int'(bus.baud_div);
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (bus.parity_en) bits.push_back((^d) ^ bus.parity_odd);
    bits.push_back(1'b1);
    if (bus.stop2) bits.push_back(1'b1);
    foreach (bits[k]) for (int j = 0; j < div; j++) exp_q.push_back(bits[k]);
  endfunction

  // One clock: sample on the falling edge, compare, advance model and FIFO.
  task automatic tick();
    logic s_rd, s_txd, s_busy, s_done, exp_rd, exp_txd;
    @(negedge clk);
    s_rd   = bus.fifo_rd_en;
    s_txd  = bus.txd;
    s_busy = bus.busy;
    s_done = bus.tx_done;
    exp_rd  = rst_n && (exp_q.size() == 0) && bus.tx_en && (fifo_q.size() != 0);
    exp_txd = (exp_q.size() != 0) ? exp_q[0] : 1'b1;
    check_eq($sformatf("txd@%0d", cyc),     32'(s_txd),  32'(exp_txd));
    check_eq($sformatf("busy@%0d", cyc),    32'(s_busy), 32'(exp_q.size() != 0));
    check_eq($sformatf("tx_done@%0d", cyc), 32'(s_done), 32'(exp_done));
    check_eq($sformatf("rd_en@%0d", cyc),   32'(s_rd),   32'(exp_rd));
    exp_done = (exp_q.size() == 1);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    if (exp_rd) model_load(fifo_q[0]);
    if (s_rd) rd_cycles.push_back(cyc);
    @(posedge clk);
    #1;
    if (s_rd && (fifo_q.size() != 0)) void'(fifo_q.pop_front());
    fifo_drive();
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cfg(input int div, input logic pe, input logic po, input logic s2);
    bus.baud_div   = VW'(div);
    bus.parity_en  = pe;
    bus.parity_odd = po;
    bus.stop2      = s2;
  endtask

  initial begin
    bus.tx_en = 1'b0;
    cfg(4, 1'b0, 1'b0, 1'b0);
    fifo_drive();

    // Reset state
    run(3);
    check_eq("reset_txd",  32'(bus.txd),        32'd1);
    check_eq("reset_busy", 32'(bus.busy),       32'd0);
    check_eq("reset_done", 32'(bus.tx_done),    32'd0);
    check_eq("reset_rd",   32'(bus.fifo_rd_en), 32'd0);
    rst_n = 1'b1;
    run(2);

    // 1) 0x55, div 4, no parity, 1 stop
    rd_cycles.delete();
    bus.tx_en = 1'b1;
    push(8'h55);
    run(50);
    check_eq("t1_pops", 32'(rd_cycles.size()), 32'd1);

    // 2) parity even / odd on 0x07, then two stop bits
    cfg(4, 1'b1, 1'b0, 1'b0); push(8'h07); run(50);
    cfg(4, 1'b1, 1'b1, 1'b0); push(8'h07); run(50);
    cfg(4, 1'b0, 1'b0, 1'b1); push(8'h07); run(55);

    // 3) back-to-back with div 2
    cfg(2, 1'b0, 1'b0, 1'b0);
    rd_cycles.delete();
    push(8'hA3); push(8'h3C);
    run(50);
    check_eq("t3_pops", 32'(rd_cycles.size()), 32'd2);
    if (rd_cycles.size() == 2)
      check_eq("t3_spacing", 32'(rd_cycles[1] - rd_cycles[0]), 32'd21);

    // 4) tx_en low with data waiting, then drop tx_en mid-frame
    bus.tx_en = 1'b0;
    rd_cycles.delete();
    push(8'hC6);
    run(20);
    check_eq("t4_no_pop", 32'(rd_cycles.size()), 32'd0);
    push(8'h11);
    bus.tx_en = 1'b1;
    run(4);
    bus.tx_en = 1'b0;
    run(40);
    check_eq("t4_one_pop",  32'(rd_cycles.size()), 32'd1);
    check_eq("t4_fifo_left", 32'(fifo_q.size()),   32'd1);
    fifo_q.delete();
    fifo_drive();

    // 5) reset in the middle of DATA
    cfg(4, 1'b0, 1'b0, 1'b0);
    bus.tx_en = 1'b1;
    push(8'h00);
    run(11);
    rst_n = 1'b0;
    #1;
    check_eq("t5_txd",  32'(bus.txd),  32'd1);
    check_eq("t5_busy", 32'(bus.busy), 32'd0);
    exp_q.delete();
    exp_done = 1'b0;
    fifo_q.delete();
    fifo_drive();
    run(2);
    rst_n = 1'b1;
    rd_cycles.delete();
    run(10);
    check_eq("t5_idle_no_pop", 32'(rd_cycles.size()), 32'd0);

    // 6) divisor 0 acts as 1; mid-frame divisor change has no effect
    cfg(0, 1'b0, 1'b0, 1'b0); push(8'h96); run(15);
    cfg(3, 1'b1, 1'b0, 1'b1); push(8'h5A); run(6);
    cfg(1, 1'b0, 1'b1, 1'b0); run(40);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if (($urandom_range(0, 9) == 0) && (fifo_q.size() < 8)) push(8'($urandom));
      if ($urandom_range(0, 19) == 0)
        cfg($urandom_range(0, 4), 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 39) == 0) bus.tx_en = ~bus.tx_en;
      tick();
    end
    bus.tx_en = 1'b1;
    run(500);
    check_eq("drain_fifo", 32'(fifo_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_tx_ctrl
`default_nettype wire
